// File: rtl/colour_palette_touch.sv
// colour_palette_touch: debounced touch picker for a row of six palette
// buttons. It presents sticker colour codes 2..7 to the cube-state editor
// while that editor holds activate high, and 0 at all other times.
module colour_palette_touch #(
    parameter int PAL_X0          = 304,
    parameter int PAL_PITCH       = 296,
    parameter int PAL_W           = 280,
    parameter int PAL_Y0          = 100,
    parameter int PAL_H           = 195,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        activate,
    input  logic [11:0] x_touch,
    input  logic [11:0] y_touch,
    input  logic        touch_input,
    output logic [2:0]  new_colour,
    output logic        colour_valid,
    output logic [2:0]  hover_idx,
    output logic        busy
);

    typedef enum logic [2:0] {
        IDLE         = 3'd0,
        WAIT_RELEASE = 3'd1,
        ARMED        = 3'd2,
        QUALIFY      = 3'd3,
        HOLD         = 3'd4
    } state_t;

    // Last count value before selection; the final hit sample completes it.
    localparam logic [7:0] COUNT_LAST = 8'(DEBOUNCE_CYCLES - 1);

    state_t      state_q, state_d;
    logic [7:0]  count_q, count_d;
    logic [2:0]  cand_q, cand_d;
    logic [2:0]  new_colour_q, new_colour_d;
    logic        colour_valid_q, colour_valid_d;
    logic [2:0]  hover_idx_q, hover_idx_d;
    logic        busy_q, busy_d;

    logic [12:0] x13, y13;
    logic        y_in_row;
    logic        hit;
    logic [2:0]  hit_idx;

    // Coordinates widened to 13 bits so upper bounds never overflow.
    assign x13      = {1'b0, x_touch};
    assign y13      = {1'b0, y_touch};
    assign y_in_row = (y13 >= 13'(PAL_Y0)) && (y13 < 13'(PAL_Y0 + PAL_H));

    // Region decode: half-open x window per button; gaps decode as no hit.
    always_comb begin
        hit     = 1'b0;
        hit_idx = 3'd0;
        for (int k = 0; k < 6; k++) begin
            if (touch_input && y_in_row &&
                (x13 >= 13'(PAL_X0 + k * PAL_PITCH)) &&
                (x13 <  13'(PAL_X0 + k * PAL_PITCH + PAL_W))) begin
                hit     = 1'b1;
                hit_idx = 3'(k);
            end
        end
    end

    // Next-state and registered-output logic; deactivation overrides everything.
    always_comb begin
        state_d        = state_q;
        count_d        = count_q;
        cand_d         = cand_q;
        new_colour_d   = new_colour_q;
        colour_valid_d = colour_valid_q;
        hover_idx_d    = hover_idx_q;

        if (!activate) begin
            state_d        = IDLE;
            count_d        = 8'd0;
            new_colour_d   = 3'd0;
            colour_valid_d = 1'b0;
            hover_idx_d    = 3'd0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    // A finger still down from picking the sticker must lift first.
                    state_d = touch_input ? WAIT_RELEASE : ARMED;
                end
                WAIT_RELEASE: begin
                    if (!touch_input) state_d = ARMED;
                end
                ARMED: begin
                    if (hit) begin
                        state_d     = QUALIFY;
                        cand_d      = hit_idx;
                        count_d     = 8'd1;
                        hover_idx_d = hit_idx + 3'd1;
                    end
                end
                QUALIFY: begin
                    if (hit && (hit_idx == cand_q)) begin
                        if (count_q == COUNT_LAST) begin
                            state_d        = HOLD;
                            new_colour_d   = cand_q + 3'd2;
                            colour_valid_d = 1'b1;
                            hover_idx_d    = 3'd0;
                        end else begin
                            count_d = count_q + 8'd1;
                        end
                    end else begin
                        // Any break restarts; a new button waits for the next sample.
                        state_d     = ARMED;
                        count_d     = 8'd0;
                        hover_idx_d = 3'd0;
                    end
                end
                HOLD: begin
                    state_d = HOLD;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        busy_d = (state_d != IDLE);
    end

    // State and output registers, cleared asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            count_q        <= 8'd0;
            cand_q         <= 3'd0;
            new_colour_q   <= 3'd0;
            colour_valid_q <= 1'b0;
            hover_idx_q    <= 3'd0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            count_q        <= count_d;
            cand_q         <= cand_d;
            new_colour_q   <= new_colour_d;
            colour_valid_q <= colour_valid_d;
            hover_idx_q    <= hover_idx_d;
            busy_q         <= busy_d;
        end
    end

    assign new_colour   = new_colour_q;
    assign colour_valid = colour_valid_q;
    assign hover_idx    = hover_idx_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_colour_palette_touch.sv
// Bench for colour_palette_touch: each cycle's stimulus pushes its expected
// outputs, the sampled outputs after the edge are queued, and each scenario
// drains and compares the two queues.
module tb_colour_palette_touch;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        activate = 1'b0;
    logic [11:0] x_touch = 12'd0;
    logic [11:0] y_touch = 12'd0;
    logic        touch_input = 1'b0;
    logic [2:0]  new_colour;
    logic        colour_valid;
    logic [2:0]  hover_idx;
    logic        busy;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [2:0] col;
        logic       vld;
        logic [2:0] hov;
        logic       bsy;
    } out_t;

    out_t exp_q[$];
    out_t obs_q[$];

    colour_palette_touch dut (
        .clk          (clk),
        .rst          (rst),
        .activate     (activate),
        .x_touch      (x_touch),
        .y_touch      (y_touch),
        .touch_input  (touch_input),
        .new_colour   (new_colour),
        .colour_valid (colour_valid),
        .hover_idx    (hover_idx),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    // One clock: drive inputs at negedge, record expectation, sample after edge.
    task automatic cyc(input logic a, input logic t, input int x, input int y,
                       input int ec, input int eh, input logic eb);
        out_t e;
        out_t o;
        @(negedge clk);
        activate    = a;
        touch_input = t;
        x_touch     = 12'(x);
        y_touch     = 12'(y);
        e.col = 3'(ec);
        e.vld = (ec != 0);
        e.hov = 3'(eh);
        e.bsy = eb;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        o.col = new_colour;
        o.vld = colour_valid;
        o.hov = hover_idx;
        o.bsy = busy;
        obs_q.push_back(o);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #1;
        checks++;
        if ({new_colour, colour_valid, hover_idx, busy} !== 8'd0) begin
            errors++;
            $display("FAIL reset_state: got col=%0d vld=%0d hov=%0d busy=%0d, want all 0",
                     new_colour, colour_valid, hover_idx, busy);
        end
        @(negedge clk);
        rst = 1'b0;
        // Activate low keeps the block idle.
        cyc(0, 0, 0, 0, 0, 0, 0);
        cyc(0, 1, 310, 150, 0, 0, 0);
        while (exp_q.size() > 0) begin
            out_t e = exp_q.pop_front();
            out_t o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL reset_idle: got col=%0d vld=%0d hov=%0d busy=%0d, want col=%0d vld=%0d hov=%0d busy=%0d",
                         o.col, o.vld, o.hov, o.bsy, e.col, e.vld, e.hov, e.bsy);
            end
        end
    endtask

    task automatic test_basic_select();
        cyc(1, 0, 0, 0, 0, 0, 1);
        cyc(1, 1, 310, 150, 0, 1, 1);
        cyc(1, 1, 310, 150, 0, 1, 1);
        cyc(1, 1, 310, 150, 0, 1, 1);
        cyc(1, 1, 310, 150, 2, 0, 1);
        cyc(1, 1, 1500, 150, 2, 0, 1);   // HOLD ignores further touches
        cyc(1, 0, 0, 0, 2, 0, 1);
        cyc(0, 0, 0, 0, 0, 0, 0);
        while (exp_q.size() > 0) begin
            out_t e = exp_q.pop_front();
            out_t o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL basic_select: got col=%0d vld=%0d hov=%0d busy=%0d, want col=%0d vld=%0d hov=%0d busy=%0d",
                         o.col, o.vld, o.hov, o.bsy, e.col, e.vld, e.hov, e.bsy);
            end
        end
    endtask

    task automatic test_right_and_gaps();
        cyc(1, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 3; i++) cyc(1, 1, 1784, 294, 0, 6, 1);
        cyc(1, 1, 1784, 294, 7, 0, 1);
        cyc(0, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 1);
        cyc(1, 1, 590, 150, 0, 0, 1);    // gap between buttons 0 and 1
        cyc(1, 1, 584, 150, 0, 0, 1);    // right edge of button 0 is exclusive
        cyc(1, 1, 304, 99, 0, 0, 1);     // just below the row
        cyc(1, 1, 304, 295, 0, 0, 1);    // top edge is exclusive
        cyc(1, 1, 2064, 150, 0, 0, 1);   // past button 5
        cyc(1, 1, 4095, 4095, 0, 0, 1);  // extreme coordinates, no wrap
        cyc(1, 0, 304, 150, 0, 0, 1);    // inside but no touch present
        cyc(1, 1, 304, 100, 0, 1, 1);    // inclusive lower-left corner
        cyc(1, 1, 583, 294, 0, 1, 1);    // last point inside button 0
        cyc(0, 1, 583, 294, 0, 0, 0);
        while (exp_q.size() > 0) begin
            out_t e = exp_q.pop_front();
            out_t o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL right_and_gaps: got col=%0d vld=%0d hov=%0d busy=%0d, want col=%0d vld=%0d hov=%0d busy=%0d",
                         o.col, o.vld, o.hov, o.bsy, e.col, e.vld, e.hov, e.bsy);
            end
        end
    endtask

    task automatic test_release_required();
        cyc(1, 1, 310, 150, 0, 0, 1);    // WAIT_RELEASE
        for (int i = 0; i < 6; i++) cyc(1, 1, 310, 150, 0, 0, 1);
        cyc(1, 0, 0, 0, 0, 0, 1);        // lift -> ARMED
        for (int i = 0; i < 3; i++) cyc(1, 1, 600, 150, 0, 2, 1);
        cyc(1, 1, 600, 150, 3, 0, 1);
        cyc(0, 0, 0, 0, 0, 0, 0);
        while (exp_q.size() > 0) begin
            out_t e = exp_q.pop_front();
            out_t o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL release_required: got col=%0d vld=%0d hov=%0d busy=%0d, want col=%0d vld=%0d hov=%0d busy=%0d",
                         o.col, o.vld, o.hov, o.bsy, e.col, e.vld, e.hov, e.bsy);
            end
        end
    endtask

    task automatic test_debounce_restart();
        cyc(1, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 3; i++) cyc(1, 1, 600, 150, 0, 2, 1);
        cyc(1, 0, 600, 150, 0, 0, 1);    // single dropout
        for (int i = 0; i < 3; i++) cyc(1, 1, 600, 150, 0, 2, 1);
        cyc(1, 1, 600, 150, 3, 0, 1);
        cyc(0, 0, 0, 0, 0, 0, 0);
        while (exp_q.size() > 0) begin
            out_t e = exp_q.pop_front();
            out_t o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL debounce_restart: got col=%0d vld=%0d hov=%0d busy=%0d, want col=%0d vld=%0d hov=%0d busy=%0d",
                         o.col, o.vld, o.hov, o.bsy, e.col, e.vld, e.hov, e.bsy);
            end
        end
    endtask

    task automatic test_candidate_switch();
        cyc(1, 0, 0, 0, 0, 0, 1);
        cyc(1, 1, 310, 150, 0, 1, 1);
        cyc(1, 1, 310, 150, 0, 1, 1);
        cyc(1, 1, 1500, 150, 0, 0, 1);   // different button -> ARMED only
        for (int i = 0; i < 3; i++) cyc(1, 1, 1500, 150, 0, 5, 1);
        cyc(1, 1, 1500, 150, 6, 0, 1);
        cyc(0, 0, 0, 0, 0, 0, 0);
        while (exp_q.size() > 0) begin
            out_t e = exp_q.pop_front();
            out_t o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL candidate_switch: got col=%0d vld=%0d hov=%0d busy=%0d, want col=%0d vld=%0d hov=%0d busy=%0d",
                         o.col, o.vld, o.hov, o.bsy, e.col, e.vld, e.hov, e.bsy);
            end
        end
    endtask

    task automatic test_abort_and_async_reset();
        cyc(1, 0, 0, 0, 0, 0, 1);
        cyc(1, 1, 310, 150, 0, 1, 1);
        cyc(1, 1, 310, 150, 0, 1, 1);
        cyc(0, 1, 310, 150, 0, 0, 0);    // abort mid-QUALIFY
        cyc(1, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 3; i++) cyc(1, 1, 310, 150, 0, 1, 1);
        cyc(0, 1, 310, 150, 0, 0, 0);    // deactivate on the final qualifying sample
        cyc(1, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 3; i++) cyc(1, 1, 900, 200, 0, 3, 1);
        cyc(1, 1, 900, 200, 4, 0, 1);    // HOLD with code 4
        while (exp_q.size() > 0) begin
            out_t e = exp_q.pop_front();
            out_t o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL abort: got col=%0d vld=%0d hov=%0d busy=%0d, want col=%0d vld=%0d hov=%0d busy=%0d",
                         o.col, o.vld, o.hov, o.bsy, e.col, e.vld, e.hov, e.bsy);
            end
        end
        // Reset between edges must clear outputs without a clock.
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({new_colour, colour_valid, hover_idx, busy} !== 8'd0) begin
            errors++;
            $display("FAIL async_reset: got col=%0d vld=%0d hov=%0d busy=%0d, want all 0",
                     new_colour, colour_valid, hover_idx, busy);
        end
        @(negedge clk);
        rst = 1'b0;
        cyc(1, 0, 0, 0, 0, 0, 1);        // re-sampled activate leaves IDLE
        cyc(0, 0, 0, 0, 0, 0, 0);
        while (exp_q.size() > 0) begin
            out_t e = exp_q.pop_front();
            out_t o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL post_reset: got col=%0d vld=%0d hov=%0d busy=%0d, want col=%0d vld=%0d hov=%0d busy=%0d",
                         o.col, o.vld, o.hov, o.bsy, e.col, e.vld, e.hov, e.bsy);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic_select();
        test_right_and_gaps();
        test_release_required();
        test_debounce_restart();
        test_candidate_switch();
        test_abort_and_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
